uart_sample_assembler: RTL and testbench

//   Consumes the byte stream from the async UART receiver (rx_ready/rx_data/rx_eop)
//   and assembles pairs of bytes into 16-bit PCM samples for the audio playback path.

---
 rtl/uart_sample_assembler.sv | 143 ++++++++++++++
 tb/tb_uart_sample_assembler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_assembler.sv
// Pairs UART bytes into 16-bit PCM samples and buffers them in a FWFT FIFO.
// Ports: rx_ready/rx_data/rx_eop in; smp_valid/smp_data/smp_ready out; fifo_level/overflow/misalign status; clr_flags.
module uart_sample_assembler #(
  parameter int FIFO_DEPTH = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_eop,
  output logic                          smp_valid,
  output logic [15:0]                   smp_data,
  input  logic                          smp_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          misalign,
  input  logic                          clr_flags
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {
    LOW_WAIT  = 1'b0,
    HIGH_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            mis_q, mis_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic            load_low;
  logic            push;
  logic            discard;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic            drop;
  logic [15:0]     sample;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOW_WAIT: begin
        if (rx_ready) state_d = HIGH_WAIT;
      end
      HIGH_WAIT: begin
        // A byte in the same cycle as eop wins; eop ignored.
        if (rx_ready || rx_eop) state_d = LOW_WAIT;
      end
      default: state_d = LOW_WAIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load_low = 1'b0;
    push     = 1'b0;
    discard  = 1'b0;
    unique case (state_q)
      LOW_WAIT:  load_low = rx_ready;
      HIGH_WAIT: begin
        push    = rx_ready;
        discard = !rx_ready && rx_eop;
      end
      default: ;
    endcase
  end

  assign sample = BIG_ENDIAN ? {hold_q, rx_data} : {rx_data, hold_q};

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign pop   = smp_valid && smp_ready;
  // When full, a concurrent pop frees the slot the new sample needs.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    mis_d    = discard;
    if (load_low) hold_d = rx_data;
    if (discard)  hold_d = 8'h00;
    if (wr_en)    wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      (wr_en && !pop): level_d = level_q + 1'b1;
      (pop && !wr_en): level_d = level_q - 1'b1;
      default:         level_d = level_q;
    endcase
    if (drop)           ovf_d = 1'b1;
    else if (clr_flags) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      mis_q    <= mis_d;
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sample;
  end

  assign smp_valid  = (level_q != '0);
  assign smp_data   = smp_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Bench for uart_sample_assembler: directed cases plus random traffic
// against a queue-based model; little- and big-endian instances side by side.
module tb_uart_sample_assembler;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_eop = 1'b0;
  logic        smp_ready = 1'b0;
  logic        clr_flags = 1'b0;

  logic        smp_valid_le, smp_valid_be;
  logic [15:0] smp_data_le, smp_data_be;
  logic [4:0]  fifo_level_le, fifo_level_be;
  logic        overflow_le, overflow_be;
  logic        misalign_le, misalign_be;

  always #5 clk = ~clk;

  uart_sample_assembler #(.FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_eop(rx_eop),
    .smp_valid(smp_valid_le), .smp_data(smp_data_le),
    .smp_ready(smp_ready), .fifo_level(fifo_level_le),
    .overflow(overflow_le), .misalign(misalign_le),
    .clr_flags(clr_flags)
  );

  uart_sample_assembler #(.FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_eop(rx_eop),
    .smp_valid(smp_valid_be), .smp_data(smp_data_be),
    .smp_ready(smp_ready), .fifo_level(fifo_level_be),
    .overflow(overflow_be), .misalign(misalign_be),
    .clr_flags(clr_flags)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: queue of byte pairs stored as {second, first}.
  logic [15:0] q[$];
  bit          have_low;
  logic [7:0]  low_byte;
  bit          m_ovf;
  bit          m_mis;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] swap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  task automatic model_reset();
    q.delete();
    have_low = 0;
    low_byte = 8'h00;
    m_ovf    = 0;
    m_mis    = 0;
  endtask

  task automatic model_edge();
    bit pop, full, push, drop;
    pop  = (q.size() != 0) && smp_ready;
    full = (q.size() == DEPTH);
    push = rx_ready && have_low;
    drop = 0;
    m_mis = !rx_ready && rx_eop && have_low;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (full && !pop) drop = 1;
      else q.push_back({rx_data, low_byte});
    end
    if (drop) m_ovf = 1;
    else if (clr_flags) m_ovf = 0;
    if (rx_ready) begin
      if (have_low) have_low = 0;
      else begin
        low_byte = rx_data;
        have_low = 1;
      end
    end else if (rx_eop) begin
      have_low = 0;
    end
  endtask

  task automatic compare();
    check("valid_le", smp_valid_le, q.size() != 0);
    check("valid_be", smp_valid_be, q.size() != 0);
    check("level", fifo_level_le, q.size());
    check("level_be", fifo_level_be, q.size());
    check("ovf", overflow_le, m_ovf);
    check("mis", misalign_le, m_mis);
    if (q.size() != 0) begin
      check("data_le", smp_data_le, q[0]);
      check("data_be", smp_data_be, swap(q[0]));
    end
  endtask

  task automatic step(input bit rdy, input logic [7:0] d, input bit eop,
                      input bit sr, input bit clr);
    rx_ready  = rdy;
    rx_data   = d;
    rx_eop    = eop;
    smp_ready = sr;
    clr_flags = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare();
    rx_ready  = 1'b0;
    rx_eop    = 1'b0;
    smp_ready = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", smp_valid_le, 1'b0);
    check("rst_data", smp_data_le, 16'h0000);
    check("rst_level", fifo_level_le, 5'd0);
    check("rst_ovf", overflow_le, 1'b0);
    check("rst_mis", misalign_le, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check("init_valid", smp_valid_le, 1'b0);
    check("init_level", fifo_level_le, 5'd0);
    rst_n = 1'b1;

    // Basic pair, both endians
    step(1, 8'h34, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    check("t1_data_le", smp_data_le, 16'h1234);
    check("t2_data_be", smp_data_be, 16'h3412);
    check("t1_level", fifo_level_le, 5'd1);
    step(0, 8'h00, 0, 1, 0);
    check("t1_empty", smp_valid_le, 1'b0);

    // Partial sample discarded on eop
    step(1, 8'hAA, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("t3_mis", misalign_le, 1'b1);
    step(0, 8'h00, 0, 0, 0);
    check("t3_mis_off", misalign_le, 1'b0);
    step(1, 8'h34, 0, 0, 0);
    step(1, 8'h12, 0, 0, 0);
    check("t3_data", smp_data_le, 16'h1234);
    check("t3_level", fifo_level_le, 5'd1);
    step(0, 8'h00, 0, 1, 0);

    // Overflow: 17 samples, drain 16 in order
    for (int k = 0; k < 17; k++) begin
      step(1, 8'(k), 0, 0, 0);
      step(1, 8'h00, 0, 0, 0);
    end
    check("t4_level", fifo_level_le, 5'd16);
    check("t4_ovf", overflow_le, 1'b1);
    for (int k = 0; k < 16; k++) begin
      check("t4_drain", smp_data_le, 16'(k));
      step(0, 8'h00, 0, 1, 0);
    end
    check("t4_empty", fifo_level_le, 5'd0);
    step(0, 8'h00, 0, 0, 1);
    check("t4_clr", overflow_le, 1'b0);

    // Full FIFO: completing sample coincides with pop
    for (int k = 0; k < 16; k++) begin
      step(1, 8'(k + 8'h40), 0, 0, 0);
      step(1, 8'h01, 0, 0, 0);
    end
    step(1, 8'hEE, 0, 0, 0);
    step(1, 8'hFF, 0, 1, 0);
    check("t5_level", fifo_level_le, 5'd16);
    check("t5_ovf", overflow_le, 1'b0);
    for (int k = 0; k < 16; k++) step(0, 8'h00, 0, 1, 0);
    check("t5_drained", fifo_level_le, 5'd0);

    // Async reset mid-sample
    step(1, 8'h55, 0, 0, 0);
    do_reset();
    step(1, 8'h78, 0, 0, 0);
    step(1, 8'h56, 0, 0, 0);
    check("t6_data", smp_data_le, 16'h5678);
    step(0, 8'h00, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 55,
           8'($urandom),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 5);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
